// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer with BOOT/RUN/HALT/FAULT control.
// It offers pc_out to the fetch stage, steps by INC on each accepted fetch,
// and redirects on branch or trap. Every output is taken straight from a
// register or decoded from the state register. No output depends on an
// input within the same cycle.
//
// Handshake: pc_out is offered while pc_valid is high, which happens only in
// RUN. A transfer ("fire") happens in a cycle where pc_valid && fetch_ready
// && !stall. On a fire, pc_out advances on the next rising edge, unless a
// trap or branch redirects it, and fetch_count increments.
module pc_seq #(
  parameter int unsigned       XLEN         = 64,
  parameter int unsigned       INC          = 4,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter logic [XLEN-1:0]   TRAP_VECTOR  = XLEN'(64'h100)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            trap,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            misaligned,
  output logic            halted,
  output logic [31:0]     fetch_count,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // Low address bits that must be zero in a branch target. INC is a power of
  // two, so INC-1 is the alignment mask. When INC=1 the mask is zero, the
  // check never fires, and FAULT cannot be reached.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);
  localparam logic [XLEN-1:0] STEP       = XLEN'(INC);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       cnt_q, cnt_d;

  logic              fire;
  logic              target_misaligned;

  assign fire              = (state_q == ST_RUN) && fetch_ready && !stall;
  assign target_misaligned = |(branch_target & ALIGN_MASK);

  // Next-state, next-PC and fetch counter selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;

    // A fire is counted even when a redirect is applied in the same cycle,
    // because the fetch stage did accept the offered pc_out. A redirect on
    // its own is never counted.
    if (fire) begin
      cnt_d = cnt_q + 32'd1;
    end

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        pc_d    = RESET_VECTOR;
      end

      ST_RUN: begin
        if (trap) begin
          // Trap wins over halt_req and over a misaligned branch.
          pc_d    = TRAP_VECTOR;
          state_d = ST_RUN;
        end else if (branch_taken) begin
          pc_d = branch_target;
          if (target_misaligned) begin
            state_d = ST_FAULT;
          end else if (halt_req) begin
            state_d = ST_HALT;
          end
        end else begin
          if (fire) begin
            pc_d = pc_q + STEP;
          end
          if (halt_req) begin
            state_d = ST_HALT;
          end
        end
      end

      ST_HALT: begin
        // branch_taken and stall are ignored here; trap has priority over resume.
        if (trap) begin
          pc_d    = TRAP_VECTOR;
          state_d = ST_RUN;
        end else if (resume) begin
          state_d = ST_RUN;
        end
      end

      ST_FAULT: begin
        // Only a trap (or reset) leaves FAULT.
        if (trap) begin
          pc_d    = TRAP_VECTOR;
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
        pc_d    = RESET_VECTOR;
      end
    endcase
  end

  // State, PC and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_out      = pc_q;
  assign pc_valid    = (state_q == ST_RUN);
  assign halted      = (state_q == ST_HALT);
  assign misaligned  = (state_q == ST_FAULT);
  assign fetch_count = cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed testbench for pc_seq (XLEN=64, INC=4, reset vector 0,
// trap vector 0x100). The driver pushes each expected post-edge snapshot into
// exp_q. The monitor pops each entry and compares it just after the
// following rising edge.
module tb_pc_seq;

  localparam int W = 101; // {state, mis, halt, valid, cnt[31:0], pc[63:0]}

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        trap;
  logic        halt_req;
  logic        resume;
  logic        fetch_ready;
  logic [63:0] pc_out;
  logic        pc_valid;
  logic        misaligned;
  logic        halted;
  logic [31:0] fetch_count;
  logic [1:0]  state_dbg;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks   = 0;
  int           failures = 0;

  pc_seq #(
    .XLEN(64), .INC(4), .RESET_VECTOR(64'h0), .TRAP_VECTOR(64'h100)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .trap(trap), .halt_req(halt_req), .resume(resume),
    .fetch_ready(fetch_ready), .pc_out(pc_out), .pc_valid(pc_valid),
    .misaligned(misaligned), .halted(halted), .fetch_count(fetch_count),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required summary before 200000");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] pack(input logic [63:0] pc, input logic valid,
                                        input logic halt, input logic mis,
                                        input logic [31:0] cnt, input logic [1:0] st);
    return {st, mis, halt, valid, cnt, pc};
  endfunction

  task automatic compare(input string name, input logic [W-1:0] exp);
    logic [W-1:0] act;
    act = pack(pc_out, pc_valid, halted, misaligned, fetch_count, state_dbg);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got st=%0d mis=%b halt=%b valid=%b cnt=%0d pc=%h, required st=%0d mis=%b halt=%b valid=%b cnt=%0d pc=%h",
               name, act[100:99], act[98], act[97], act[96], act[95:64], act[63:0],
               exp[100:99], exp[98], exp[97], exp[96], exp[95:64], exp[63:0]);
    end
  endtask

  // Monitor: one expected entry per rising edge, sampled 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        compare(name_q.pop_front(), exp_q.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 64'h0;
    trap          = 1'b0;
    halt_req      = 1'b0;
    resume        = 1'b0;
    fetch_ready   = 1'b0;
  endtask

  // Driver: inputs are already set; queue the expected state after the next
  // edge, then return on the following falling edge with inputs idled.
  task automatic expect_next(input string name, input logic [63:0] pc,
                             input logic valid, input logic halt, input logic mis,
                             input logic [31:0] cnt, input logic [1:0] st);
    exp_q.push_back(pack(pc, valid, halt, mis, cnt, st));
    name_q.push_back(name);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_branch(input logic [63:0] tgt);
    branch_taken  = 1'b1;
    branch_target = tgt;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    compare("reset_hold", pack(64'h0, 1'b0, 1'b0, 1'b0, 32'd0, S_BOOT));

    reset = 1'b0;
    #1;
    compare("boot_after_release", pack(64'h0, 1'b0, 1'b0, 1'b0, 32'd0, S_BOOT));
    expect_next("boot_to_run", 64'h0, 1, 0, 0, 32'd0, S_RUN);

    // Sequential advance with a stall in the middle.
    fetch_ready = 1'b1;
    expect_next("fire1", 64'h4, 1, 0, 0, 32'd1, S_RUN);
    fetch_ready = 1'b1; stall = 1'b1;
    expect_next("stalled", 64'h4, 1, 0, 0, 32'd1, S_RUN);
    fetch_ready = 1'b1;
    expect_next("fire2", 64'h8, 1, 0, 0, 32'd2, S_RUN);
    expect_next("no_ready_hold", 64'h8, 1, 0, 0, 32'd2, S_RUN);

    // Trap beats branch and halt_req.
    do_branch(64'h8000_0000); trap = 1'b1; halt_req = 1'b1;
    expect_next("trap_over_branch", 64'h100, 1, 0, 0, 32'd2, S_RUN);
    do_branch(64'h8000_0000);
    expect_next("branch_only", 64'h8000_0000, 1, 0, 0, 32'd2, S_RUN);

    // Misaligned branch -> FAULT, held until trap.
    do_branch(64'h1002);
    expect_next("misaligned_branch", 64'h1002, 0, 0, 1, 32'd2, S_FAULT);
    fetch_ready = 1'b1;
    expect_next("fault_hold_ready", 64'h1002, 0, 0, 1, 32'd2, S_FAULT);
    fetch_ready = 1'b1; resume = 1'b1; halt_req = 1'b1; do_branch(64'h2000);
    expect_next("fault_ignores_other", 64'h1002, 0, 0, 1, 32'd2, S_FAULT);
    trap = 1'b1;
    expect_next("fault_trap_exit", 64'h100, 1, 0, 0, 32'd2, S_RUN);

    // Halt entered with a fire in the same cycle.
    do_branch(64'h10);
    expect_next("branch_to_10", 64'h10, 1, 0, 0, 32'd2, S_RUN);
    fetch_ready = 1'b1; halt_req = 1'b1;
    expect_next("halt_with_fire", 64'h14, 0, 1, 0, 32'd3, S_HALT);
    do_branch(64'h3000); stall = 1'b1; fetch_ready = 1'b1;
    expect_next("halt_ignores_branch", 64'h14, 0, 1, 0, 32'd3, S_HALT);
    resume = 1'b1;
    expect_next("resume", 64'h14, 1, 0, 0, 32'd3, S_RUN);
    fetch_ready = 1'b1;
    expect_next("fire_after_resume", 64'h18, 1, 0, 0, 32'd4, S_RUN);
    halt_req = 1'b1;
    expect_next("halt_no_fire", 64'h18, 0, 1, 0, 32'd4, S_HALT);
    trap = 1'b1; resume = 1'b1;
    expect_next("halt_trap_over_resume", 64'h100, 1, 0, 0, 32'd4, S_RUN);

    // Wrap at the top of the address space.
    do_branch(64'hFFFF_FFFF_FFFF_FFFC);
    expect_next("branch_to_top", 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 32'd4, S_RUN);
    fetch_ready = 1'b1;
    expect_next("pc_wrap", 64'h0, 1, 0, 0, 32'd5, S_RUN);

    // Asynchronous reset between edges.
    do_branch(64'h2000);
    expect_next("branch_to_2000", 64'h2000, 1, 0, 0, 32'd5, S_RUN);
    #2;
    reset = 1'b1;
    #1;
    compare("async_reset", pack(64'h0, 1'b0, 1'b0, 1'b0, 32'd0, S_BOOT));
    @(negedge clk);
    fetch_ready = 1'b1;
    expect_next("reset_held_over_edge", 64'h0, 0, 0, 0, 32'd0, S_BOOT);
    reset = 1'b0;
    #1;
    compare("boot_after_rerelease", pack(64'h0, 1'b0, 1'b0, 1'b0, 32'd0, S_BOOT));
    expect_next("boot_to_run_again", 64'h0, 1, 0, 0, 32'd0, S_RUN);
    fetch_ready = 1'b1;
    expect_next("fire_after_reset", 64'h4, 1, 0, 0, 32'd1, S_RUN);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter XLEN, default 64, PC width in bits.
REQ-002 Parameter INC, default 4, sequential PC step in bytes; power of two, at least 1.
REQ-003 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-004 Parameter TRAP_VECTOR, default 64'h100 (truncated to XLEN), PC value loaded on trap.
REQ-005 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 stall  in  1  freeze sequential advance.
REQ-009 branch_taken  in  1  redirect request this cycle.
REQ-010 branch_target  in  XLEN  redirect address.
REQ-011 trap  in  1  exception request; loads TRAP_VECTOR.
REQ-012 halt_req  in  1  request to enter HALT.
REQ-013 resume  in  1  leave HALT.
REQ-014 fetch_ready  in  1  fetch stage accepts pc_out.
REQ-015 pc_out  out  XLEN  current PC.
REQ-016 pc_valid  out  1  pc_out offered to fetch.
REQ-017 misaligned  out  1  high in FAULT state.
REQ-018 halted  out  1  high in HALT state.
REQ-019 fetch_count  out  32  number of accepted fetches.

Function
REQ-020 States SHALL be BOOT, RUN, HALT and FAULT, registered.
REQ-021 pc_valid SHALL be 1 only in RUN; halted 1 only in HALT; misaligned 1 only in FAULT.
REQ-022 A fire SHALL occur in a cycle where pc_valid, fetch_ready and !stall are all 1.
REQ-023 BOOT SHALL go to RUN on the first clock edge after reset deasserts, with pc_out held at RESET_VECTOR.
REQ-024 In RUN, the next PC SHALL be chosen by priority: trap gives TRAP_VECTOR; else branch_taken gives branch_target; else a fire gives pc_out+INC; else pc_out is held.
REQ-025 Trap and branch SHALL apply regardless of stall and fetch_ready.
REQ-026 pc_out+INC SHALL wrap modulo 2^XLEN with no flag; FFFF_FFFF_FFFF_FFFC+4 gives 0.
REQ-027 fetch_count SHALL increment by 1 on each fire, wrap modulo 2^32, and never count redirects.
REQ-028 In RUN, halt_req with no trap SHALL give HALT next cycle; a branch or fire in the same cycle still updates PC per REQ-024.
REQ-029 In RUN, a branch_target whose low log2(INC) bits are nonzero SHALL be loaded into pc_out and move the state to FAULT.
REQ-030 In RUN, trap SHALL move the state to RUN, overriding halt_req and a misaligned branch.
REQ-031 In HALT, pc_out SHALL be held and branch_taken and stall ignored; resume gives RUN next cycle.
REQ-032 In HALT, trap SHALL load TRAP_VECTOR and give RUN, taking priority over resume.
REQ-033 In FAULT, pc_out SHALL be held and only trap (giving TRAP_VECTOR and RUN) or reset exits.
REQ-034 With INC=1 the misalignment check SHALL be disabled and FAULT is unreachable.
REQ-035 The block SHALL have no combinational path from any input to any output.

Reset
REQ-036 While reset is high: pc_out=RESET_VECTOR, state=BOOT, pc_valid=0, halted=0, misaligned=0, fetch_count=0, asynchronously and independent of clk.
REQ-037 Reset asserted mid-operation in any state SHALL override all other inputs immediately; behaviour after release follows REQ-023.

Verification (XLEN=64, INC=4, RESET_VECTOR=0, TRAP_VECTOR=0x100)
REQ-038 Assert reset between clock edges with pc_out=0x2000 -> pc_out=0, pc_valid=0 before next edge; release -> one BOOT cycle, then pc_valid=1, pc_out=0.
REQ-039 fetch_ready=1 for 3 edges, stall on 2nd -> pc_out 0->4->4->8, fetch_count=2.
REQ-040 branch_taken=1, target=0x8000_0000, same cycle trap=1 -> pc_out=0x100, state RUN; next cycle branch only -> pc_out=0x8000_0000.
REQ-041 branch_target=0x1002 -> pc_out=0x1002, misaligned=1, pc_valid=0, held under fetch_ready; trap -> pc_out=0x100, RUN.
REQ-042 halt_req at pc_out=0x10 with fire -> pc_out=0x14, halted=1, fetch_count frozen; branch ignored; resume -> RUN, pc_out=0x14.
REQ-043 Branch to 0xFFFF_FFFF_FFFF_FFFC, then fire -> pc_out=0, fetch_count+1, no fault.
